// File: rtl/rp_acq_seq_pkg.sv
`default_nettype none
// ============================================================
// rp_acq_pkg : state encoding shared by the acquisition sequencer
// Rev 1.0
// ============================================================
package rp_acq_pkg;

  localparam int ACQ_SW = 3;

  typedef logic [ACQ_SW-1:0] acq_state_t;

  localparam acq_state_t ACQ_IDLE = 3'd0;
  localparam acq_state_t ACQ_PRE  = 3'd1;
  localparam acq_state_t ACQ_WAIT = 3'd2;
  localparam acq_state_t ACQ_POST = 3'd3;
  localparam acq_state_t ACQ_DONE = 3'd4;

  function automatic logic f_capturing(input acq_state_t st);
    return (st == ACQ_PRE) || (st == ACQ_WAIT) || (st == ACQ_POST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rp_acq_seq_if.sv
`default_nettype none
// ============================================================
// rp_acq_seq_if : control/status bundle of the acquisition sequencer
// Rev 1.0
// ============================================================
interface rp_acq_seq_if
  import rp_acq_pkg::*;
#(
  parameter int AW = 14,
  parameter int CW = 32
);
  logic              arm_i;
  logic              abort_i;
  logic [3:0]        trg_src_i;
  logic [CW-1:0]     pre_len_i;
  logic [CW-1:0]     dly_i;
  logic              adc_dv_i;
  logic              trig_i;
  logic [3:0]        set_trg_src_o;
  logic              set_trg_new_o;
  logic              trig_dis_clr_o;
  logic              adc_dly_do_o;
  logic              adc_rst_do_o;
  logic              buf_we_o;
  logic [AW-1:0]     buf_waddr_o;
  logic [AW-1:0]     trig_addr_o;
  logic [ACQ_SW-1:0] state_o;
  logic              done_o;

  modport master (
    input  arm_i, abort_i, trg_src_i, pre_len_i, dly_i, adc_dv_i, trig_i,
    output set_trg_src_o, set_trg_new_o, trig_dis_clr_o, adc_dly_do_o,
           adc_rst_do_o, buf_we_o, buf_waddr_o, trig_addr_o, state_o, done_o
  );

  modport slave (
    output arm_i, abort_i, trg_src_i, pre_len_i, dly_i, adc_dv_i, trig_i,
    input  set_trg_src_o, set_trg_new_o, trig_dis_clr_o, adc_dly_do_o,
           adc_rst_do_o, buf_we_o, buf_waddr_o, trig_addr_o, state_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/rp_acq_seq_cnt.sv
`default_nettype none
// ============================================================
// rp_acq_cnt : saturating sample counter with terminal compare
// Rev 1.0
// ============================================================
module rp_acq_cnt #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [CW-1:0] i_term,
  output logic          o_hit
);
  localparam logic [CW-1:0] c_MAX = '1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && (r_cnt != c_MAX)) w_cnt_nxt = r_cnt + CW'(1);
  end

  // Compare against the post-increment value so the terminal count is seen
  // on the same cycle as the strobe that reaches it.
  assign o_hit = (w_cnt_nxt >= i_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else r_cnt <= w_cnt_nxt;
  end
endmodule
`default_nettype wire

// File: rtl/rp_acq_seq.sv
`default_nettype none
// ============================================================
// rp_acq_seq : per-channel ADC acquisition sequencer
// Rev 1.0
// ============================================================
module rp_acq_seq
  import rp_acq_pkg::*;
#(
  parameter int AW = 14,
  parameter int CW = 32
) (
  input logic          adc_clk_i,
  input logic          adc_rstn_i,
  rp_acq_seq_if.master bus
);
  // Buffer depth in CW+1 bits; saturates to all-ones when the depth cannot be exceeded.
  localparam logic [CW:0] c_DEPTH = (AW >= CW) ? {(CW+1){1'b1}} : ((CW+1)'(1) << AW);

  acq_state_t    r_state;
  acq_state_t    w_state_nxt;
  logic          w_arm_acc;
  logic          w_trig_acc;
  logic          w_pre_hit;
  logic          w_post_hit;
  logic          w_pre_inc;
  logic          w_post_inc;
  logic          w_cnt_clr;
  logic [CW-1:0] w_pre_term;
  logic [CW-1:0] r_pre_term;
  logic [CW-1:0] r_dly;
  logic [3:0]    r_set_trg_src;
  logic          r_set_trg_new;
  logic          r_trig_dis_clr;
  logic          r_dly_do;
  logic          r_rst_do;
  logic          r_buf_we;
  logic [AW-1:0] r_waddr;
  logic [AW-1:0] r_trig_addr;
  logic          r_done;

  always_comb begin
    w_pre_term = bus.pre_len_i;
    if ({1'b0, bus.pre_len_i} > c_DEPTH) w_pre_term = c_DEPTH[CW-1:0];
  end

  assign w_pre_inc  = bus.adc_dv_i && (r_state == ACQ_PRE);
  assign w_post_inc = bus.adc_dv_i && (r_state == ACQ_POST);
  assign w_cnt_clr  = w_arm_acc || bus.abort_i;

  rp_acq_cnt #(.CW(CW)) u_pre_cnt (
    .clk    (adc_clk_i),
    .rst_n  (adc_rstn_i),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_pre_inc),
    .i_term (r_pre_term),
    .o_hit  (w_pre_hit)
  );

  rp_acq_cnt #(.CW(CW)) u_post_cnt (
    .clk    (adc_clk_i),
    .rst_n  (adc_rstn_i),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_post_inc),
    .i_term (r_dly),
    .o_hit  (w_post_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_arm_acc   = 1'b0;
    w_trig_acc  = 1'b0;
    if (bus.abort_i) begin
      w_state_nxt = ACQ_IDLE;
    end else begin
      case (r_state)
        ACQ_IDLE, ACQ_DONE: if (bus.arm_i) begin
          w_state_nxt = ACQ_PRE;
          w_arm_acc   = 1'b1;
        end
        ACQ_PRE:  if (w_pre_hit) w_state_nxt = ACQ_WAIT;
        ACQ_WAIT: if (bus.trig_i) begin
          w_state_nxt = ACQ_POST;
          w_trig_acc  = 1'b1;
        end
        ACQ_POST: if (w_post_hit) w_state_nxt = ACQ_DONE;
        default:  w_state_nxt = ACQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_state        <= ACQ_IDLE;
      r_pre_term     <= '0;
      r_dly          <= '0;
      r_set_trg_src  <= '0;
      r_set_trg_new  <= 1'b0;
      r_trig_dis_clr <= 1'b0;
      r_dly_do       <= 1'b0;
      r_rst_do       <= 1'b0;
      r_buf_we       <= 1'b0;
      r_waddr        <= '0;
      r_trig_addr    <= '0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_trig_dis_clr <= w_arm_acc;
      r_rst_do       <= bus.abort_i;
      r_set_trg_new  <= (r_state == ACQ_PRE) && (w_state_nxt == ACQ_WAIT);
      r_dly_do       <= (r_state == ACQ_POST) && (w_state_nxt == ACQ_DONE);
      r_done         <= (w_state_nxt == ACQ_DONE);
      r_buf_we       <= bus.adc_dv_i && f_capturing(r_state);
      r_waddr        <= r_waddr + AW'(r_buf_we);
      if (w_arm_acc) begin
        r_pre_term <= w_pre_term;
        r_dly      <= bus.dly_i;
      end
      if ((r_state == ACQ_PRE) && (w_state_nxt == ACQ_WAIT)) r_set_trg_src <= bus.trg_src_i;
      if (w_trig_acc) r_trig_addr <= r_waddr;
    end
  end

  assign bus.set_trg_src_o  = r_set_trg_src;
  assign bus.set_trg_new_o  = r_set_trg_new;
  assign bus.trig_dis_clr_o = r_trig_dis_clr;
  assign bus.adc_dly_do_o   = r_dly_do;
  assign bus.adc_rst_do_o   = r_rst_do;
  assign bus.buf_we_o       = r_buf_we;
  assign bus.buf_waddr_o    = r_waddr;
  assign bus.trig_addr_o    = r_trig_addr;
  assign bus.state_o        = r_state;
  assign bus.done_o         = r_done;
endmodule
`default_nettype wire
